// File: rtl/instr_encoder_loader_if.sv
// Field/handshake and instruction-memory write bus for instr_encoder_loader.
// master: program source (bench or boot path); slave: the encoder/loader.
interface instr_encoder_loader_if;
  logic        load_start;
  logic        load_end;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  kind;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [15:0] instr_count;
  logic        done;
  logic        range_err;

  modport master (
    output load_start, load_end, in_valid, kind, funct3, funct7, rd, rs1, rs2, imm,
    input  in_ready, imem_we, imem_addr, imem_wdata, instr_count, done, range_err
  );

  modport slave (
    input  load_start, load_end, in_valid, kind, funct3, funct7, rd, rs1, rs2, imm,
    output in_ready, imem_we, imem_addr, imem_wdata, instr_count, done, range_err
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Builds RV32 R/I/S/B/U/J words from decoded fields and writes them sequentially to imem.
// Optional immediate range checking is enabled by defining INSTR_RANGE_CHECK_EN.
module instr_encoder_loader #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic                    clk,
  input logic                    rst,
  instr_encoder_loader_if.slave  bus
);

  localparam logic [6:0]  OpR = 7'b0110011;
  localparam logic [6:0]  OpI = 7'b0010011;
  localparam logic [6:0]  OpS = 7'b0100011;
  localparam logic [6:0]  OpB = 7'b1100011;
  localparam logic [6:0]  OpU = 7'b0110111;
  localparam logic [6:0]  OpJ = 7'b1101111;
  localparam logic [15:0] DepthLast = 16'(DEPTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        range_err_q, range_err_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        in_ready;
  logic        accept;
  logic        kind_ok;
  logic        imm_ok;
  logic        do_write;
  logic        do_drop;
  logic [31:0] enc_word;
  logic [31:0] imm;

  assign imm = bus.imm;

  // Instruction word assembly; invalid kinds produce 0 but are never written.
  always_comb begin
    enc_word = 32'h0;
    kind_ok  = 1'b1;
    unique case (bus.kind)
      3'd0: enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, OpR};
      3'd1: enc_word = {imm[11:0], bus.rs1, bus.funct3, bus.rd, OpI};
      3'd2: enc_word = {imm[11:5], bus.rs2, bus.rs1, bus.funct3, imm[4:0], OpS};
      3'd3: enc_word = {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3, imm[4:1], imm[11],
                        OpB};
      3'd4: enc_word = {imm[31:12], bus.rd, OpU};
      3'd5: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, OpJ};
      default: kind_ok = 1'b0;
    endcase
  end

`ifdef INSTR_RANGE_CHECK_EN
  // The immediate must round-trip through its encoded field unchanged.
  always_comb begin
    imm_ok = 1'b1;
    unique case (bus.kind)
      3'd1, 3'd2: imm_ok = (imm == {{20{imm[11]}}, imm[11:0]});
      3'd3:       imm_ok = (imm == {{19{imm[12]}}, imm[12:0]}) && !imm[0];
      3'd4:       imm_ok = (imm[11:0] == 12'h000);
      3'd5:       imm_ok = (imm == {{11{imm[20]}}, imm[20:0]}) && !imm[0];
      default:    imm_ok = 1'b1;
    endcase
  end
`else
  logic unused_imm;
  assign imm_ok     = 1'b1;
  assign unused_imm = imm[0];
`endif

  assign in_ready = (state_q == StLoad);
  assign accept   = bus.in_valid && in_ready;
  // A restart discards any word offered in the same cycle.
  assign do_write = accept && !bus.load_start && kind_ok && imm_ok;
  assign do_drop  = accept && !bus.load_start && !(kind_ok && imm_ok);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    range_err_d = range_err_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;

    if (do_write) begin
      we_d    = 1'b1;
      addr_d  = BASE_ADDR + {14'b0, count_q, 2'b00};
      wdata_d = enc_word;
      count_d = count_q + 16'd1;
    end
    if (do_drop) begin
      range_err_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.load_start) state_d = StLoad;
      end
      StLoad: begin
        if (bus.load_start) begin
          state_d = StLoad;
        end else if (bus.load_end || (do_write && count_q == DepthLast)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.load_start) state_d = StLoad;
      end
      default: state_d = StIdle;
    endcase

    if (bus.load_start) begin
      count_d     = 16'd0;
      range_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= 16'd0;
      range_err_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      range_err_q <= range_err_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.imem_we     = we_q;
  assign bus.imem_addr   = addr_q;
  assign bus.imem_wdata  = wdata_q;
  assign bus.instr_count = count_q;
  assign bus.done        = (state_q == StDone);
  assign bus.range_err   = range_err_q;

endmodule
